// File: rtl/tlul_pkg.sv
// Shared TL-UL response-channel types and the helper that picks the fields
// covered by response integrity.
package tlul_pkg;

  localparam int D2HRspMaxWidth = 57;
  localparam int DataMaxWidth   = 57;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d2h_user_t;

  typedef struct packed {
    logic         d_valid;
    logic [2:0]   d_opcode;
    logic [2:0]   d_param;
    logic [1:0]   d_size;
    logic [7:0]   d_source;
    logic [0:0]   d_sink;
    logic [31:0]  d_data;
    tl_d2h_user_t d_user;
    logic         d_error;
    logic         a_ready;
  } tl_d2h_t;

  // Response integrity protects opcode, size and error only.
  function automatic logic [D2HRspMaxWidth-1:0] extract_d2h_rsp_intg(tl_d2h_t tl);
    return D2HRspMaxWidth'({tl.d_opcode, tl.d_size, tl.d_error});
  endfunction

endpackage

// File: rtl/prim_secded_64_57_enc.sv
// Extended Hamming (64,57) encoder: six position-weighted check bits plus an
// overall parity bit. The all-zero word encodes to zero check bits.
module prim_secded_64_57_enc (
  input  logic [56:0] data_i,
  output logic [6:0]  ecc_o
);

  always_comb begin
    logic [5:0] d;
    logic [5:0] chk;
    d   = '0;
    chk = '0;
    // Data bits occupy the codeword positions 1..63 that are not powers of two.
    for (int p = 1; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (data_i[d]) chk = chk ^ 6'(p);
        d = d + 6'd1;
      end
    end
    ecc_o = {^{data_i, chk}, chk};
  end

endmodule

// File: rtl/tlul_rsp_intg_gen.sv
// Regenerates response and (optionally) data integrity on a D-channel beat.
module tlul_rsp_intg_gen
  import tlul_pkg::*;
#(
  parameter bit EnableRspIntgGen  = 1'b1,
  parameter bit EnableDataIntgGen = 1'b1
) (
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);

  logic [6:0] rsp_ecc;
  logic [6:0] data_ecc;

  prim_secded_64_57_enc u_rsp_enc (
    .data_i(extract_d2h_rsp_intg(tl_i)),
    .ecc_o (rsp_ecc)
  );

  prim_secded_64_57_enc u_data_enc (
    .data_i(DataMaxWidth'(tl_i.d_data)),
    .ecc_o (data_ecc)
  );

  always_comb begin
    tl_o = tl_i;
    if (EnableRspIntgGen)  tl_o.d_user.rsp_intg  = rsp_ecc;
    if (EnableDataIntgGen) tl_o.d_user.data_intg = data_ecc;
  end

endmodule

// File: rtl/tlul_rsp_arb.sv
// Merges N TL-UL D channels into one registered, integrity-regenerated stream.
// Define TLUL_RSP_ARB_RR_EN for round-robin; otherwise lowest index wins.
module tlul_rsp_arb
  import tlul_pkg::*;
#(
  parameter int unsigned N                 = 4,
  parameter bit          EnableDataIntgGen = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  tl_d2h_t       tl_dev_i [N],
  output logic [N-1:0]  dev_ready_o,
  output tl_d2h_t       tl_host_o,
  input  logic          host_d_ready_i,
  output logic [N-1:0]  gnt_o,
  output logic          busy_o
);

  localparam int unsigned ArbIdxW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a source beat transfers on a cycle where its d_valid and
  // dev_ready_o[i] are both high; the host beat transfers on d_valid && host_d_ready_i.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  tl_d2h_t              rsp_q, rsp_out;
  logic [N-1:0]         gnt_q, sel_onehot, req;
  logic [ArbIdxW-1:0]   sel;
  logic                 load;

  always_comb begin
    for (int i = 0; i < int'(N); i++) req[i] = tl_dev_i[i].d_valid;
  end

`ifdef TLUL_RSP_ARB_RR_EN
  logic [ArbIdxW-1:0] ptr_q;
  logic [ArbIdxW-1:0] idx;

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    logic found;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = ArbIdxW'((32'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   ptr_q <= ArbIdxW'(N - 1);
    else if (load) ptr_q <= sel;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) sel = ArbIdxW'(i);
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      sel_onehot[i]  = (sel == ArbIdxW'(i));
      dev_ready_o[i] = load && (sel == ArbIdxW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    load    = ((state_q == EMPTY) || host_d_ready_i) && (|req);
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (host_d_ready_i && !load) state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      rsp_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rsp_q <= tl_dev_i[sel];
        gnt_q <= sel_onehot;
      end else if (state_d == EMPTY) begin
        gnt_q <= '0;
      end
    end
  end

  always_comb begin
    rsp_out         = rsp_q;
    rsp_out.d_valid = (state_q == FULL);
  end

  tlul_rsp_intg_gen #(
    .EnableRspIntgGen (1'b1),
    .EnableDataIntgGen(EnableDataIntgGen)
  ) u_intg_gen (
    .tl_i(rsp_out),
    .tl_o(tl_host_o)
  );

  assign gnt_o  = gnt_q;
  assign busy_o = (state_q == FULL);

endmodule

// File: tb/tb_tlul_rsp_arb.sv
// Directed bench for tlul_rsp_arb (N=4): vector table plus hold, reset and
// arbitration-order sequences, with a source-index scoreboard.
module tb_tlul_rsp_arb;
  import tlul_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  tl_d2h_t    tl_dev [4];
  logic [3:0] dev_ready;
  tl_d2h_t    tl_host;
  logic       host_rdy = 1'b0;
  logic [3:0] gnt;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  tlul_rsp_arb #(.N(4), .EnableDataIntgGen(1'b1)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tl_dev_i      (tl_dev),
    .dev_ready_o   (dev_ready),
    .tl_host_o     (tl_host),
    .host_d_ready_i(host_rdy),
    .gnt_o         (gnt),
    .busy_o        (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference (64,57) code computed check bit by check bit.
  function automatic logic [6:0] ecc_model(input logic [56:0] d);
    int pos [57];
    int p;
    logic [6:0] c;
    p = 0;
    c = '0;
    for (int i = 0; i < 57; i++) begin
      p++;
      while ((p & (p - 1)) == 0) p++;
      pos[i] = p;
    end
    for (int j = 0; j < 6; j++)
      for (int i = 0; i < 57; i++)
        if (((pos[i] >> j) & 1) == 1) c[j] = c[j] ^ d[i];
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  function automatic tl_d2h_t src_payload(input int i);
    tl_d2h_t t;
    t = '0;
    t.d_source = 8'(8'h10 + i);
    t.d_param  = 3'(i);
    t.d_sink   = 1'(i);
    case (i)
      0: begin t.d_opcode = 3'h0; t.d_size = 2'd2; t.d_data = 32'h0123_4567; end
      1: begin t.d_opcode = 3'h1; t.d_size = 2'd2; t.d_data = 32'h89AB_CDEF;
               t.d_user = 14'h3FFF; end
      2: begin t.d_opcode = 3'h1; t.d_size = 2'd1; t.d_data = 32'hDEAD_BEEF;
               t.a_ready = 1'b1; end
      default: begin t.d_opcode = 3'h0; t.d_size = 2'd0; t.d_data = 32'hCAFE_F00D;
                     t.d_error = 1'b1; end
    endcase
    return t;
  endfunction

  function automatic tl_d2h_t expected_beat(input int i);
    tl_d2h_t t;
    t = src_payload(i);
    t.d_valid            = 1'b1;
    t.d_user.rsp_intg    = ecc_model(57'({t.d_opcode, t.d_size, t.d_error}));
    t.d_user.data_intg   = ecc_model(57'(t.d_data));
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs (caller is at a negedge) and check outputs.
  task automatic apply_check(input logic [3:0] vld, input logic hrdy, input logic [3:0] exp_rdy,
                             input logic exp_busy, input logic [3:0] exp_gnt, input string tag);
    for (int i = 0; i < 4; i++) begin
      tl_dev[i] = src_payload(i);
      tl_dev[i].d_valid = vld[i];
    end
    host_rdy = hrdy;
    #1;
    chk({tag, ".rdy"}, 128'(dev_ready), 128'(exp_rdy));
    chk({tag, ".busy"}, 128'(busy), 128'(exp_busy));
    chk({tag, ".gnt"}, 128'(gnt), 128'(exp_gnt));
    if (exp_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s.sb actual=beat required=empty_queue", tag);
      end else begin
        chk({tag, ".beat"}, 128'(tl_host), 128'(expected_beat(int'(exp_q[0]))));
      end
    end else begin
      chk({tag, ".dvalid"}, 128'(tl_host.d_valid), 128'(1'b0));
    end
    if (exp_busy && hrdy && exp_q.size() > 0) void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) exp_q.push_back(2'(i));
  endtask

  typedef struct {
    logic [3:0] vld;
    logic       hrdy;
    logic [3:0] rdy;
    logic       busy;
    logic [3:0] gnt;
  } vec_t;

  vec_t tbl [11];
  logic [3:0] seq_vld [7];
  logic [3:0] seq_rdy [7];

  initial begin
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0100};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[3]  = '{4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000};
    tbl[4]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 4'b0010};
    tbl[5]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 4'b0010};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'b1000};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 4'b0000};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0001};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0001};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};

    seq_vld = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110};
`ifdef TLUL_RSP_ARB_RR_EN
    seq_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
`else
    seq_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`endif

    for (int i = 0; i < 4; i++) begin
      tl_dev[i] = src_payload(i);
      tl_dev[i].d_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset.host", 128'(tl_host), 128'(0));
    chk("reset.gnt", 128'(gnt), 128'(0));
    chk("reset.busy", 128'(busy), 128'(0));
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      apply_check(tbl[v].vld, tbl[v].hrdy, tbl[v].rdy, tbl[v].busy, tbl[v].gnt,
                  $sformatf("tbl%0d", v));
    end

    // Host stalls for five cycles while FULL, then releases into a back-to-back load.
    @(negedge clk);
    apply_check(4'b0100, 1'b0, 4'b0100, 1'b0, 4'b0000, "hold0");
    for (int h = 1; h <= 5; h++) begin
      @(negedge clk);
      apply_check(4'b0011, 1'b0, 4'b0000, 1'b1, 4'b0100, $sformatf("hold%0d", h));
    end
    @(negedge clk);
    apply_check(4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0100, "release");
    @(negedge clk);
    apply_check(4'b0011, 1'b0, 4'b0000, 1'b1, 4'b0001, "full_again");

    // Reset lands mid-cycle while a beat is held.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.host", 128'(tl_host), 128'(0));
    chk("async_rst.gnt", 128'(gnt), 128'(0));
    chk("async_rst.busy", 128'(busy), 128'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply_check(seq_vld[0], 1'b1, seq_rdy[0], 1'b0, 4'b0000, "seq0");
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      apply_check(seq_vld[k], 1'b1, seq_rdy[k], 1'b1, seq_rdy[k-1], $sformatf("seq%0d", k));
    end
    @(negedge clk);
    apply_check(4'b0000, 1'b1, 4'b0000, 1'b1, seq_rdy[6], "drain");
    @(negedge clk);
    apply_check(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, "idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
